// File: rtl/avmm_arb_pkg.sv
// rtl/avmm_arb_pkg.sv - shared state type, default widths and burst helper for the 2:1 Avalon-MM arbiter
// Contents:
//   arb_state_e  arbiter FSM states (IDLE, RD_CMD, RD_DATA, WR_BURST)
//   DEF_*_W      default address/data/burstcount widths
//   burst_len()  burstcount to beat count, a burstcount of 0 is one beat
package avmm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_CMD   = 2'd1,
    RD_DATA  = 2'd2,
    WR_BURST = 2'd3
  } arb_state_e;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_BURST_W = 4;

  // Widest burstcount the helper accepts; callers zero-extend into it.
  localparam int MAX_BURST_W = 16;

  function automatic logic [MAX_BURST_W-1:0] burst_len(input logic [MAX_BURST_W-1:0] bc);
    return (bc == '0) ? MAX_BURST_W'(1) : bc;
  endfunction

endpackage

// File: rtl/avmm_arb_pick.sv
// rtl/avmm_arb_pick.sv - combinational winner selection for the 2:1 arbiter
// Ports:
//   req[1:0]    request per master (read | write)
//   last_grant  master that owned the previous transaction
//   winner      index of the master to grant
// Build option: AVMM_ARB_FIXED_PRIO_EN selects fixed priority (master 1 wins ties).
module avmm_arb_pick
  import avmm_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       winner
);

`ifdef AVMM_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
  assign winner            = req[1];
`else
  // A lone requester always wins; a tie goes to the master that did not go last.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) begin
      winner = ~last_grant;
    end
  end
`endif

endmodule

// File: rtl/avmm_arbiter_2to1.sv
// rtl/avmm_arbiter_2to1.sv - two-master Avalon-MM arbiter in front of the external slave port
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   m0_* / m1_*           master ports (m0 instruction fetch, m1 data/LSU)
//   ext_s_*               shared external slave port
//   grant                 index of the master owning the slave port
//   err_rdv               sticky: readdatavalid seen outside a read data phase
// A grant is held for a whole transaction: a write burst, or a read command plus all its beats.
// Build option: AVMM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module avmm_arbiter_2to1
  import avmm_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BURST_W = DEF_BURST_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [BURST_W-1:0]    m0_burstcount,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [BURST_W-1:0]    m1_burstcount,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     ext_s_address,
  output logic                  ext_s_read,
  output logic                  ext_s_write,
  output logic [DATA_W-1:0]     ext_s_writedata,
  output logic [DATA_W/8-1:0]   ext_s_byteenable,
  output logic [BURST_W-1:0]    ext_s_burstcount,
  input  logic                  ext_s_waitrequest,
  input  logic [DATA_W-1:0]     ext_s_readdata,
  input  logic                  ext_s_readdatavalid,
  output logic                  grant,
  output logic                  err_rdv
);

  localparam logic [BURST_W-1:0] BEAT_ONE = BURST_W'(1);

  arb_state_e           state;
  logic [BURST_W-1:0]   beats;
  logic                 last_grant;
  logic                 winner;
  logic                 win_write;
  logic [1:0]           req;
  logic                 in_cmd;
  logic                 rd_accept;
  logic                 wr_accept;
  logic                 rd_beat;

  logic                 g_read;
  logic                 g_write;
  logic [ADDR_W-1:0]    g_address;
  logic [DATA_W-1:0]    g_writedata;
  logic [DATA_W/8-1:0]  g_byteenable;
  logic [BURST_W-1:0]   g_burstcount;
  logic [BURST_W-1:0]   g_len;

  assign req       = {m1_read | m1_write, m0_read | m0_write};
  assign win_write = winner ? m1_write : m0_write;

  avmm_arb_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .winner     (winner)
  );

  always_comb begin
    g_read       = m0_read;
    g_write      = m0_write;
    g_address    = m0_address;
    g_writedata  = m0_writedata;
    g_byteenable = m0_byteenable;
    g_burstcount = m0_burstcount;
    if (grant) begin
      g_read       = m1_read;
      g_write      = m1_write;
      g_address    = m1_address;
      g_writedata  = m1_writedata;
      g_byteenable = m1_byteenable;
      g_burstcount = m1_burstcount;
    end
  end

  assign g_len = BURST_W'(burst_len(MAX_BURST_W'(g_burstcount)));

  assign in_cmd           = (state == RD_CMD) || (state == WR_BURST);
  assign ext_s_address    = in_cmd ? g_address    : '0;
  assign ext_s_writedata  = in_cmd ? g_writedata  : '0;
  assign ext_s_byteenable = in_cmd ? g_byteenable : '0;
  assign ext_s_burstcount = in_cmd ? g_burstcount : '0;
  // Each command state only forwards its own command, so a master flipping
  // read/write mid-grant can never present the other command to the slave.
  assign ext_s_read       = (state == RD_CMD)   && g_read;
  assign ext_s_write      = (state == WR_BURST) && g_write;

  assign m0_waitrequest   = (in_cmd && !grant) ? ext_s_waitrequest : 1'b1;
  assign m1_waitrequest   = (in_cmd &&  grant) ? ext_s_waitrequest : 1'b1;

  assign m0_readdata      = ext_s_readdata;
  assign m1_readdata      = ext_s_readdata;
  assign rd_beat          = (state == RD_DATA) && ext_s_readdatavalid;
  assign m0_readdatavalid = rd_beat && !grant;
  assign m1_readdatavalid = rd_beat &&  grant;

  assign rd_accept        = ext_s_read  && !ext_s_waitrequest;
  assign wr_accept        = ext_s_write && !ext_s_waitrequest;

  // beats == 0 in WR_BURST marks "first beat not yet accepted"; every
  // transaction leaves the counter at 0 when it returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      beats      <= '0;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      err_rdv    <= 1'b0;
    end else begin
      if (ext_s_readdatavalid && (state != RD_DATA)) begin
        err_rdv <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= winner;
            state <= win_write ? WR_BURST : RD_CMD;
          end
        end
        RD_CMD: begin
          if (rd_accept) begin
            beats      <= g_len;
            last_grant <= grant;
            state      <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (ext_s_readdatavalid) begin
            beats <= beats - BEAT_ONE;
            if (beats == BEAT_ONE) begin
              state <= IDLE;
            end
          end
        end
        WR_BURST: begin
          if (wr_accept) begin
            if (beats == '0) begin
              if (g_len == BEAT_ONE) begin
                state      <= IDLE;
                last_grant <= grant;
              end else begin
                beats <= g_len - BEAT_ONE;
              end
            end else if (beats == BEAT_ONE) begin
              beats      <= '0;
              state      <= IDLE;
              last_grant <= grant;
            end else begin
              beats <= beats - BEAT_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read and write together from one master is illegal; write takes precedence in hardware.
  a_m0_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(m0_read && m0_write));
  a_m1_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(m1_read && m1_write));

endmodule

// File: tb/tb_avmm_arbiter_2to1.sv
// tb/tb_avmm_arbiter_2to1.sv - scoreboard bench for avmm_arbiter_2to1
module tb_avmm_arbiter_2to1;
  import avmm_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m_read [2];
  logic        m_write [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_be [2];
  logic [3:0]  m_bc [2];
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] ext_s_address, ext_s_writedata, ext_s_readdata;
  logic        ext_s_read, ext_s_write, ext_s_waitrequest, ext_s_readdatavalid;
  logic [3:0]  ext_s_byteenable, ext_s_burstcount;
  logic        grant, err_rdv;

  avmm_arbiter_2to1 dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address(m_addr[0]), .m0_read(m_read[0]), .m0_write(m_write[0]),
    .m0_writedata(m_wdata[0]), .m0_byteenable(m_be[0]), .m0_burstcount(m_bc[0]),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m_addr[1]), .m1_read(m_read[1]), .m1_write(m_write[1]),
    .m1_writedata(m_wdata[1]), .m1_byteenable(m_be[1]), .m1_burstcount(m_bc[1]),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ext_s_address(ext_s_address), .ext_s_read(ext_s_read), .ext_s_write(ext_s_write),
    .ext_s_writedata(ext_s_writedata), .ext_s_byteenable(ext_s_byteenable),
    .ext_s_burstcount(ext_s_burstcount), .ext_s_waitrequest(ext_s_waitrequest),
    .ext_s_readdata(ext_s_readdata), .ext_s_readdatavalid(ext_s_readdatavalid),
    .grant(grant), .err_rdv(err_rdv)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [3:0]  bc;
    int          gap_after;
  } cmd_t;
  typedef struct packed { logic g; logic [3:0] bc; logic [31:0] addr; } rcmd_t;
  typedef struct packed { logic g; logic [3:0] be; logic [31:0] addr; logic [31:0] data; } wbeat_t;
  typedef struct packed { logic g; logic [31:0] data; } rbeat_t;

  cmd_t        mq0[$], mq1[$];
  rcmd_t       rc_sb[$];
  wbeat_t      wb_sb[$];
  rbeat_t      rd_sb[$];
  logic [31:0] slv_data_q[$];

  int n_pass = 0, n_total = 0;
  int cyc = 0;
  int rd_acc_cyc [2];
  int last_rdv_cyc [2];
  int last_wr_cyc = 0;
  int m_wait_cnt [2];
  bit m_busy [2];
  int stall_left = 0, pend = 0;
  bit stray_req = 1'b0, rd_slow = 1'b0, tog = 1'b0, cmd_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: event not allowed or timed out", name);
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic master_proc(input int n);
    cmd_t c;
    int   nb, guard;
    bit   acc;
    forever begin
      @(posedge clk);
      #1;
      if ((n == 0 && mq0.size() > 0) || (n == 1 && mq1.size() > 0)) begin
        if (n == 0) c = mq0.pop_front();
        else        c = mq1.pop_front();
        m_busy[n] = 1'b1;
        nb = (c.bc == 4'd0) ? 1 : int'(c.bc);
        if (!c.wr) nb = 1;
        m_addr[n] = c.addr;
        m_be[n]   = c.be;
        m_bc[n]   = c.bc;
        for (int b = 0; b < nb; b++) begin
          m_wdata[n] = c.data + 32'(b);
          m_read[n]  = !c.wr;
          m_write[n] = c.wr;
          guard = 0;
          m_wait_cnt[n] = 0;
          do begin
            @(negedge clk);
            acc = (n == 0) ? !m0_waitrequest : !m1_waitrequest;
            if (!acc) m_wait_cnt[n]++;
            @(posedge clk);
            #1;
            guard++;
          end while (!acc && guard < 400);
          if (!acc) fail_now("master_accept_timeout");
          if (b == c.gap_after) begin
            m_write[n] = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        m_read[n]  = 1'b0;
        m_write[n] = 1'b0;
        m_busy[n]  = 1'b0;
      end
    end
  endtask

  initial master_proc(0);
  initial master_proc(1);

  // Slave model: optional command stall, read beats returned from slv_data_q.
  initial begin
    ext_s_waitrequest   = 1'b0;
    ext_s_readdatavalid = 1'b0;
    ext_s_readdata      = '0;
    forever begin
      @(negedge clk);
      cmd_seen = ext_s_read || ext_s_write;
      if (ext_s_read && !ext_s_waitrequest)
        pend += (ext_s_burstcount == 4'd0) ? 1 : int'(ext_s_burstcount);
      @(posedge clk);
      #2;
      if (cmd_seen && stall_left > 0) stall_left--;
      ext_s_waitrequest   = (stall_left > 0);
      ext_s_readdatavalid = 1'b0;
      tog = !tog;
      if (stray_req) begin
        ext_s_readdatavalid = 1'b1;
        ext_s_readdata      = 32'h5A5A5A5A;
        stray_req           = 1'b0;
      end else if (pend > 0 && slv_data_q.size() > 0 && (!rd_slow || tog)) begin
        ext_s_readdatavalid = 1'b1;
        ext_s_readdata      = slv_data_q.pop_front();
        pend--;
      end
    end
  end

  // Monitor: every beat/accept the DUT presents is matched against the scoreboards.
  initial begin
    rbeat_t eb;
    rcmd_t  ec;
    wbeat_t ew;
    forever begin
      @(negedge clk);
      if (m0_readdatavalid || m1_readdatavalid) begin
        if (m0_readdatavalid && m1_readdatavalid) fail_now("rdv_both_masters");
        if (rd_sb.size() == 0) fail_now("rdv_unexpected_beat");
        else begin
          eb = rd_sb.pop_front();
          chk("rd_beat", 128'({m1_readdatavalid, m1_readdatavalid ? m1_readdata : m0_readdata}), 128'(eb));
        end
        last_rdv_cyc[m1_readdatavalid ? 1 : 0] = cyc;
      end
      if (ext_s_read && !ext_s_waitrequest) begin
        if (rc_sb.size() == 0) fail_now("rd_cmd_unexpected");
        else begin
          ec = rc_sb.pop_front();
          chk("rd_cmd", 128'({grant, ext_s_burstcount, ext_s_address}), 128'(ec));
        end
        rd_acc_cyc[grant ? 1 : 0] = cyc;
      end
      if (ext_s_write && !ext_s_waitrequest) begin
        if (wb_sb.size() == 0) fail_now("wr_beat_unexpected");
        else begin
          ew = wb_sb.pop_front();
          chk("wr_beat", 128'({grant, ext_s_byteenable, ext_s_address, ext_s_writedata}), 128'(ew));
        end
        last_wr_cyc = cyc;
      end
    end
  end

  task automatic wait_done(input string name);
    int g = 0;
    while ((mq0.size() > 0 || mq1.size() > 0 || m_busy[0] || m_busy[1] || rd_sb.size() > 0 ||
            rc_sb.size() > 0 || wb_sb.size() > 0) && g < 600) begin
      step(1);
      g++;
    end
    if (g >= 600) fail_now(name);
    step(2);
  endtask

  function automatic cmd_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] be, input logic [3:0] bc, input int gap);
    cmd_t c;
    c.wr = wr; c.addr = addr; c.data = data; c.be = be; c.bc = bc; c.gap_after = gap;
    return c;
  endfunction

  initial begin
    int g;
    for (int i = 0; i < 2; i++) begin
      m_read[i] = 0; m_write[i] = 0; m_addr[i] = 0; m_wdata[i] = 0; m_be[i] = 0; m_bc[i] = 0;
      m_busy[i] = 0; m_wait_cnt[i] = 0; rd_acc_cyc[i] = 0; last_rdv_cyc[i] = 0;
    end
    step(3);
    chk("rst_ext_cmd", 128'({ext_s_read, ext_s_write}), 128'(2'b00));
    chk("rst_grant_err", 128'({grant, err_rdv}), 128'(2'b00));
    chk("rst_waitreq", 128'({m0_waitrequest, m1_waitrequest}), 128'(2'b11));
    chk("rst_rdv", 128'({m0_readdatavalid, m1_readdatavalid}), 128'(2'b00));
    rst_n = 1'b1;
    step(2);

    // Simultaneous requests: A(m0), B(m1), then C(m0) ties with pending B.
    slv_data_q.push_back(32'h11111111);
    slv_data_q.push_back(32'h22222222);
    slv_data_q.push_back(32'h33333333);
`ifdef AVMM_ARB_FIXED_PRIO_EN
    rc_sb.push_back('{1'b1, 4'd1, 32'h20});
    rc_sb.push_back('{1'b0, 4'd1, 32'h10});
    rd_sb.push_back('{1'b1, 32'h11111111});
    rd_sb.push_back('{1'b0, 32'h22222222});
`else
    rc_sb.push_back('{1'b0, 4'd1, 32'h10});
    rc_sb.push_back('{1'b1, 4'd1, 32'h20});
    rd_sb.push_back('{1'b0, 32'h11111111});
    rd_sb.push_back('{1'b1, 32'h22222222});
`endif
    rc_sb.push_back('{1'b0, 4'd1, 32'h30});
    rd_sb.push_back('{1'b0, 32'h33333333});
    mq0.push_back(mk(1'b0, 32'h10, 0, 4'hF, 4'd1, -1));
    mq1.push_back(mk(1'b0, 32'h20, 0, 4'hF, 4'd1, -1));
    mq0.push_back(mk(1'b0, 32'h30, 0, 4'hF, 4'd1, -1));
    wait_done("rr_timeout");

    // Single read, slave stalls the command two cycles.
    stall_left = 2;
    slv_data_q.push_back(32'hDEADBEEF);
    rc_sb.push_back('{1'b0, 4'd1, 32'h100});
    rd_sb.push_back('{1'b0, 32'hDEADBEEF});
    mq0.push_back(mk(1'b0, 32'h100, 0, 4'hF, 4'd1, -1));
    g = 0;
    while (rd_sb.size() > 0 && g < 100) begin step(1); g++; end
    chk("single_rd_state_idle", 128'(dut.state), 128'(IDLE));
    chk("single_rd_wait_cycles", 128'(m_wait_cnt[0]), 128'(3));
    wait_done("single_rd_timeout");

    // m1 write burst of 4 with a gap; m0 read arrives while the burst owns the port.
    mq1.push_back(mk(1'b1, 32'h500, 32'hC0DE0000, 4'h3, 4'd4, 1));
    for (int i = 0; i < 4; i++) wb_sb.push_back('{1'b1, 4'h3, 32'h500, 32'hC0DE0000 + 32'(i)});
    step(3);
    slv_data_q.push_back(32'h66666666);
    rc_sb.push_back('{1'b0, 4'd1, 32'h600});
    rd_sb.push_back('{1'b0, 32'h66666666});
    mq0.push_back(mk(1'b0, 32'h600, 0, 4'hF, 4'd1, -1));
    wait_done("wr_burst_timeout");
    chk("m0_held_off_until_idle", 128'(rd_acc_cyc[0] - last_wr_cyc), 128'(2));

    // m0 read burst of 8 with beats spaced out; m1 requests mid-burst.
    rd_slow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      slv_data_q.push_back(32'h20000000 + 32'(i));
      rd_sb.push_back('{1'b0, 32'h20000000 + 32'(i)});
    end
    rc_sb.push_back('{1'b0, 4'd8, 32'h200});
    mq0.push_back(mk(1'b0, 32'h200, 0, 4'hF, 4'd8, -1));
    step(4);
    slv_data_q.push_back(32'h30303030);
    rd_sb.push_back('{1'b1, 32'h30303030});
    rc_sb.push_back('{1'b1, 4'd1, 32'h300});
    mq1.push_back(mk(1'b0, 32'h300, 0, 4'hF, 4'd1, -1));
    wait_done("rd_burst_timeout");
    chk("m1_blocked_until_8th_beat", 128'(rd_acc_cyc[1] - last_rdv_cyc[0]), 128'(2));
    rd_slow = 1'b0;

    // Stray readdatavalid while idle.
    chk("err_rdv_clear_before_stray", 128'(err_rdv), 128'(0));
    stray_req = 1'b1;
    step(3);
    chk("err_rdv_set_by_stray", 128'(err_rdv), 128'(1));
    step(5);
    chk("err_rdv_sticky", 128'(err_rdv), 128'(1));

    // Reset during RD_DATA with 3 of 5 beats outstanding.
    slv_data_q.push_back(32'h00000071);
    slv_data_q.push_back(32'h00000072);
    rc_sb.push_back('{1'b1, 4'd5, 32'h700});
    rd_sb.push_back('{1'b1, 32'h00000071});
    rd_sb.push_back('{1'b1, 32'h00000072});
    mq1.push_back(mk(1'b0, 32'h700, 0, 4'hF, 4'd5, -1));
    g = 0;
    while (rd_sb.size() > 0 && g < 100) begin step(1); g++; end
    step(1);
    chk("pre_rst_state_rd_data", 128'({dut.state, grant}), 128'({RD_DATA, 1'b1}));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 128'(dut.state), 128'(IDLE));
    chk("mid_rst_grant_err", 128'({grant, err_rdv}), 128'(2'b00));
    chk("mid_rst_waitreq", 128'({m0_waitrequest, m1_waitrequest, ext_s_read, ext_s_write}), 128'(4'b1100));
    step(1);
    rst_n = 1'b1;
    slv_data_q.push_back(32'h00000073);
    slv_data_q.push_back(32'h00000074);
    slv_data_q.push_back(32'h00000075);
    step(6);
    chk("post_rst_beats_drained", 128'(slv_data_q.size()), 128'(0));
    chk("post_rst_err_rdv", 128'(err_rdv), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
